qdrc_softcal_sampler: RTL

- Datapath-side partner of the soft-calibration register block. Runs in the QDR clock domain.
- Steers the per-bit IODELAY and half-cycle-align controls to the bit picked by bit_select.
- Samples that bit's rise/fall read data SAMPLE_COUNT times and reports data_in, data_sampled, data_valid and cal_rdy back to software.
- Control strobes arrive already synchronised to clk by the existing crossing stage.

---
 rtl/qdrc_softcal_pkg.sv | 18 +
 rtl/qdrc_softcal_bitmux.sv | 26 ++
 rtl/qdrc_softcal_sampler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/qdrc_softcal_pkg.sv
// Shared types and defaults for the QDR soft-calibration sampler.
// Optional error counter is built when QDRC_SOFTCAL_ERRCNT_EN is defined.
package qdrc_softcal_pkg;

  localparam int SEL_W             = 8;
  localparam int DEF_SAMPLE_COUNT  = 32;
  localparam int DEF_SETTLE_CYCLES = 1024;
  localparam int DEF_FLUSH_CYCLES  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/qdrc_softcal_bitmux.sv
// Picks the rise/fall bit under calibration and decodes bit_select
// one-hot; selects beyond DATA_WIDTH read 2'b00 and drive no bit.
module qdrc_softcal_bitmux
  import qdrc_softcal_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_WIDTH-1:0] rise,
  input  logic [DATA_WIDTH-1:0] fall,
  output logic [1:0]            bit_rf,
  output logic [DATA_WIDTH-1:0] onehot
);

  always_comb begin
    bit_rf = 2'b00;
    onehot = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (32'(sel) == i) begin
        onehot[i] = 1'b1;
        bit_rf    = {rise[i], fall[i]};
      end
    end
  end

endmodule

// File: rtl/qdrc_softcal_sampler.sv
// QDR-domain soft-cal datapath: steers IODELAY/align, samples one bit.
// Define QDRC_SOFTCAL_ERRCNT_EN to add the err_count output.
module qdrc_softcal_sampler
  import qdrc_softcal_pkg::*;
#(
  parameter int DATA_WIDTH    = 36,
  parameter int SAMPLE_COUNT  = DEF_SAMPLE_COUNT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int FLUSH_CYCLES  = DEF_FLUSH_CYCLES
) (
`ifdef QDRC_SOFTCAL_ERRCNT_EN
  output logic [15:0]           err_count,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cal_en,
  input  logic [SEL_W-1:0]      bit_select,
  input  logic                  dll_en,
  input  logic                  dll_inc_dec_n,
  input  logic                  dll_rst,
  input  logic                  align_en,
  input  logic                  align_strb,
  input  logic [DATA_WIDTH-1:0] rd_data_rise,
  input  logic [DATA_WIDTH-1:0] rd_data_fall,
  input  logic                  rd_valid,
  output logic                  cal_rdy,
  output logic [1:0]            data_in,
  output logic                  data_sampled,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] dly_ce,
  output logic                  dly_inc,
  output logic [DATA_WIDTH-1:0] dly_rst,
  output logic [DATA_WIDTH-1:0] align_vec
);

  localparam int STW = $clog2(SETTLE_CYCLES + 1);
  localparam int FW  = $clog2(FLUSH_CYCLES + 1);
  localparam int SW  = $clog2(SAMPLE_COUNT + 1);

  state_t           state;
  logic [STW-1:0]   stcnt;
  logic [FW-1:0]    fcnt;
  logic [SW-1:0]    scnt;
  logic [SEL_W-1:0] sel_q;
  logic             dll_rst_q;
  logic             mis;
  logic             restart;
  logic             run;
  logic             diff;
  logic [1:0]       smp;
  logic [DATA_WIDTH-1:0] onehot;

  qdrc_softcal_bitmux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bitmux (
    .sel    (bit_select),
    .rise   (rd_data_rise),
    .fall   (rd_data_fall),
    .bit_rf (smp),
    .onehot (onehot)
  );

  assign restart = dll_en | align_strb
                 | (dll_rst ^ dll_rst_q)
                 | (bit_select != sel_q);
  assign run  = state inside {ST_FLUSH, ST_SAMPLE, ST_HOLD};
  assign diff = smp != data_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_ce    <= '0;
      dly_rst   <= '0;
      dly_inc   <= 1'b0;
      sel_q     <= '0;
      dll_rst_q <= 1'b0;
      align_vec <= '0;
    end else begin
      dly_ce    <= onehot & {DATA_WIDTH{dll_en}};
      dly_rst   <= onehot & {DATA_WIDTH{dll_rst}};
      dly_inc   <= dll_inc_dec_n;
      sel_q     <= bit_select;
      dll_rst_q <= dll_rst;
      if (align_strb)
        align_vec <= (align_vec & ~onehot)
                   | (onehot & {DATA_WIDTH{align_en}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      stcnt        <= '0;
      fcnt         <= '0;
      scnt         <= '0;
      mis          <= 1'b0;
      cal_rdy      <= 1'b0;
      data_in      <= 2'b00;
      data_sampled <= 1'b0;
      data_valid   <= 1'b0;
    end else if (!cal_en) begin
      state        <= ST_IDLE;
      stcnt        <= '0;
      fcnt         <= '0;
      scnt         <= '0;
      mis          <= 1'b0;
      cal_rdy      <= 1'b0;
      data_sampled <= 1'b0;
      data_valid   <= 1'b0;
    end else if (restart && run) begin
      // restart beats a final sample landing on the same edge
      state        <= ST_FLUSH;
      fcnt         <= '0;
      scnt         <= '0;
      mis          <= 1'b0;
      data_sampled <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          stcnt <= STW'(1);
          fcnt  <= '0;
          if (SETTLE_CYCLES <= 1) begin
            cal_rdy <= 1'b1;
            state   <= ST_FLUSH;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (stcnt == STW'(SETTLE_CYCLES - 1)) begin
            cal_rdy <= 1'b1;
            fcnt    <= '0;
            state   <= ST_FLUSH;
          end else begin
            stcnt <= stcnt + STW'(1);
          end
        end
        ST_FLUSH: begin
          if (fcnt == FW'(FLUSH_CYCLES - 1)) begin
            scnt  <= '0;
            state <= ST_SAMPLE;
          end else begin
            fcnt <= fcnt + FW'(1);
          end
        end
        ST_SAMPLE: begin
          if (rd_valid) begin
            if (scnt == '0) begin
              data_in <= smp;
              mis     <= 1'b0;
            end else if (diff) begin
              mis <= 1'b1;
            end
            if (scnt == SW'(SAMPLE_COUNT - 1)) begin
              data_sampled <= 1'b1;
              data_valid   <= !(mis || (scnt != '0 && diff));
              state        <= ST_HOLD;
            end else begin
              scnt <= scnt + SW'(1);
            end
          end
        end
        ST_HOLD: begin
          if (rd_valid && diff)
            data_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef QDRC_SOFTCAL_ERRCNT_EN
  logic cmp_err;

  assign cmp_err = rd_valid && diff
                 && ((state == ST_SAMPLE && scnt != '0)
                     || state == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_count <= '0;
    else if (!cal_en || restart)
      err_count <= '0;
    else if (cmp_err && err_count != 16'hFFFF)
      err_count <= err_count + 16'd1;
  end
`endif

endmodule
